hdmi_link_sequencer: RTL and testbench
======================================

Name: hdmi_link_sequencer

Overview:
- Bring-up and pattern-scheduling controller for the pixel-clock HDMI test-pattern path: VGA timing generator, pattern generator, and the hdmi_tx serializer.
- Holds the serializer in reset until the PLL lock is stable, then enables pattern output aligned to a frame boundary.
- Sequences the 4-bit pattern mode (0x01..0x0B) from manual step, direct load, or auto-advance requests.
- All mode changes occur only at frame boundaries, so no frame is ever torn.

Parameters:
- MODE_MIN, 1: lowest legal pattern mode; reset and wrap target.
- MODE_MAX, 11: highest legal pattern mode (0x0B, grid scan).
- FRAMES_PER_MODE, 120: frames per mode when auto-advance is enabled; legal range 1..65535.
- SETTLE_CYCLES, 1024: consecutive locked cycles required before serializer reset release; must be ≥1.
- VS_ACTIVE_HIGH, 0: VGA_VS_I polarity; 0 means the active level is low.

Ports:
- PXLCLK_I  in  1  pixel clock; sole clock.
- RST_I  in  1  asynchronous, active-high reset.
- LOCKED_I  in  1  PLL lock, synchronous to PXLCLK_I.
- VGA_VS_I  in  1  vsync from the timing generator.
- AUTO_EN_I  in  1  level; enables auto-advance.
- STEP_I  in  1  pulse; request advance to the next mode.
- SEL_LOAD_I  in  1  pulse; request load of MODE_SEL_I.
- MODE_SEL_I  in  4  direct mode value, sampled when SEL_LOAD_I=1.
- TPG_MODE_O  out  4  current pattern mode.
- DEN_TPG_O  out  1  pattern output enable.
- TX_RST_N_O  out  1  serializer reset, active-low.
- FRAME_START_O  out  1  one-cycle pulse per frame boundary.
- PENDING_O  out  1  a mode-change request is latched and waiting.
- STATE_O  out  2  FSM state, for debug.

Behaviour:
- Reset values:
  - TPG_MODE_O=MODE_MIN; DEN_TPG_O=0; TX_RST_N_O=0; FRAME_START_O=0; PENDING_O=0; STATE_O=WAIT_LOCK.
  - Settle counter and frame counter = 0.
- Frame boundary:
  - VS register delayed one cycle; boundary = transition into the active level (falling edge when VS_ACTIVE_HIGH=0).
  - FRAME_START_O is registered and asserts the cycle after the edge is seen.
  - Boundaries are detected in every state; they act only in ALIGN and RUN.
- FSM (STATE_O: WAIT_LOCK=0, SETTLE=1, ALIGN=2, RUN=3):
  - WAIT_LOCK: TX_RST_N_O=0, DEN_TPG_O=0. Settle counter cleared. LOCKED_I=1 → SETTLE.
  - SETTLE: counter increments while LOCKED_I=1. LOCKED_I=0 → WAIT_LOCK, counter cleared. Counter reaches SETTLE_CYCLES-1 → ALIGN.
  - ALIGN: TX_RST_N_O=1, DEN_TPG_O=0. First boundary → RUN; DEN_TPG_O=1 in the same cycle FRAME_START_O=1.
  - RUN: TX_RST_N_O=1, DEN_TPG_O=1.
  - LOCKED_I=0 in ALIGN or RUN → WAIT_LOCK. Next cycle: TX_RST_N_O=0, DEN_TPG_O=0, pending request cleared, frame counter cleared, TPG_MODE_O retained.
- Requests (accepted in any state except WAIT_LOCK):
  - SEL_LOAD_I with MODE_SEL_I in [MODE_MIN, MODE_MAX]: latch a load of that value. An out-of-range value is ignored and any existing pending request is unchanged.
  - STEP_I: latch a step, unless a load is already pending.
  - SEL_LOAD_I and STEP_I in the same cycle: the load wins and the step is dropped.
  - A later load overwrites a pending step or an earlier load.
  - Multiple steps before one boundary still give a single advance.
  - PENDING_O=1 from the cycle after the request until the boundary that applies it.
- Mode update (only in RUN, only on a boundary cycle, TPG_MODE_O registered in that same cycle):
  - Pending load → the loaded value.
  - Else pending step → next mode, where next = MODE_MAX ? MODE_MIN : mode+1.
  - Else AUTO_EN_I=1 and frame counter = FRAMES_PER_MODE-1 → next mode.
  - A request pending at ALIGN→RUN is applied at that first boundary.
- Frame counter:
  - 16 bits; increments on each RUN boundary.
  - Cleared on any mode change and whenever AUTO_EN_I=0.
  - Saturates at 0xFFFF; no wrap.
- Mid-operation reset: asserting RST_I forces all reset values immediately, asynchronously.

Test Plan:
- Reset, then LOCKED_I=1 at t0 with SETTLE_CYCLES=16 → TX_RST_N_O rises 16 cycles after t0. DEN_TPG_O stays 0 until the first VS falling edge, then rises together with FRAME_START_O. TPG_MODE_O=1 throughout.
- LOCKED_I pulses low for 1 cycle at SETTLE count 10 → back to WAIT_LOCK. Release occurs only after a full 16 fresh locked cycles.
- In RUN with mode=0x0B, STEP_I pulsed 3 times within one frame → PENDING_O=1. At the boundary TPG_MODE_O=0x01 (single advance, wrap) and PENDING_O=0.
- SEL_LOAD_I=1 with MODE_SEL_I=0x09 in the same cycle as STEP_I → mode becomes 0x09 at the next boundary. SEL_LOAD_I with 0x0C or 0x00 → ignored; PENDING_O stays 0.
- AUTO_EN_I=1 with FRAMES_PER_MODE=3, starting at mode 1 → mode changes to 2, 3, 4 on every 3rd FRAME_START_O. Dropping AUTO_EN_I for one frame restarts the count.
- LOCKED_I=0 in RUN with a load of 0x05 pending → next cycle TX_RST_N_O=0, DEN_TPG_O=0, PENDING_O=0, mode unchanged. On re-lock and ALIGN the mode is still the old value.

Source files
------------

// File: rtl/hdmi_link_sequencer.sv
// hdmi_link_sequencer: bring-up and pattern-mode scheduler for the HDMI test-pattern path.
// Waits for a stable PLL lock, releases the serializer reset, then enables the pattern
// generator on a frame boundary. Pattern mode changes (step, load, auto-advance) are
// applied only on frame boundaries.
//
// Ports:
//   PXLCLK_I       pixel clock (sole clock)
//   RST_I          asynchronous active-high reset
//   LOCKED_I       PLL lock, synchronous to PXLCLK_I
//   VGA_VS_I       vsync from the timing generator (polarity set by VS_ACTIVE_HIGH)
//   AUTO_EN_I      level, enables auto-advance every FRAMES_PER_MODE frames
//   STEP_I         pulse, request advance to the next mode
//   SEL_LOAD_I     pulse, request load of MODE_SEL_I
//   MODE_SEL_I     direct mode value
//   TPG_MODE_O     current pattern mode
//   DEN_TPG_O      pattern output enable
//   TX_RST_N_O     serializer reset, active-low
//   FRAME_START_O  one-cycle pulse per frame boundary
//   PENDING_O      a mode-change request is waiting for a boundary
//   STATE_O        FSM state (debug)
module hdmi_link_sequencer #(
    parameter int MODE_MIN        = 1,
    parameter int MODE_MAX        = 11,
    parameter int FRAMES_PER_MODE = 120,
    parameter int SETTLE_CYCLES   = 1024,
    parameter bit VS_ACTIVE_HIGH  = 1'b0
) (
    input  logic       PXLCLK_I,
    input  logic       RST_I,
    input  logic       LOCKED_I,
    input  logic       VGA_VS_I,
    input  logic       AUTO_EN_I,
    input  logic       STEP_I,
    input  logic       SEL_LOAD_I,
    input  logic [3:0] MODE_SEL_I,
    output logic [3:0] TPG_MODE_O,
    output logic       DEN_TPG_O,
    output logic       TX_RST_N_O,
    output logic       FRAME_START_O,
    output logic       PENDING_O,
    output logic [1:0] STATE_O
);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_SETTLE    = 2'd1,
        S_ALIGN     = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    MIN4        = 4'(MODE_MIN);
    localparam logic [3:0]    MAX4        = 4'(MODE_MAX);
    localparam logic [15:0]   FPM_LAST    = 16'(FRAMES_PER_MODE - 1);

    state_t        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          vs_act_q;
    logic          fs_q;
    logic [3:0]    mode_q, mode_d;
    logic          pl_q, pl_d;
    logic          ps_q, ps_d;
    logic [3:0]    lv_q, lv_d;
    logic [15:0]   fcnt_q, fcnt_d;

    logic       vs_act;
    logic       vs_edge;
    logic       linked;
    logic       lock_lost;
    logic       bnd_run;
    logic       load_ok;
    logic       auto_hit;
    logic       chg;
    logic [3:0] next_mode;

    // Normalise vsync so the boundary is always "becoming active".
    assign vs_act    = VS_ACTIVE_HIGH ? VGA_VS_I : ~VGA_VS_I;
    assign vs_edge   = vs_act & ~vs_act_q;
    assign linked    = (state_q == S_ALIGN) || (state_q == S_RUN);
    assign lock_lost = linked && !LOCKED_I;
    // The ALIGN->RUN boundary is the first RUN frame, so it applies requests too.
    assign bnd_run   = vs_edge && linked && LOCKED_I;
    assign load_ok   = SEL_LOAD_I && (MODE_SEL_I >= MIN4) && (MODE_SEL_I <= MAX4);
    assign auto_hit  = AUTO_EN_I && (fcnt_q == FPM_LAST);
    assign next_mode = (mode_q == MAX4) ? MIN4 : mode_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        unique case (state_q)
            S_WAIT_LOCK: begin
                settle_d = '0;
                if (LOCKED_I) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (!LOCKED_I) begin
                    state_d  = S_WAIT_LOCK;
                    settle_d = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d  = S_ALIGN;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            S_ALIGN: begin
                if (!LOCKED_I) state_d = S_WAIT_LOCK;
                else if (vs_edge) state_d = S_RUN;
            end
            S_RUN: begin
                if (!LOCKED_I) state_d = S_WAIT_LOCK;
            end
        endcase
    end

    always_comb begin
        pl_d   = pl_q;
        ps_d   = ps_q;
        lv_d   = lv_q;
        mode_d = mode_q;
        fcnt_d = fcnt_q;
        chg    = 1'b0;
        if (state_q == S_WAIT_LOCK || lock_lost) begin
            pl_d   = 1'b0;
            ps_d   = 1'b0;
            fcnt_d = '0;
        end else begin
            if (bnd_run) begin
                if (pl_q) begin
                    mode_d = lv_q;
                    chg    = 1'b1;
                end else if (ps_q || auto_hit) begin
                    mode_d = next_mode;
                    chg    = 1'b1;
                end
                pl_d = 1'b0;
                ps_d = 1'b0;
            end
            // Load beats step; repeated steps collapse into one flag.
            if (load_ok) begin
                pl_d = 1'b1;
                ps_d = 1'b0;
                lv_d = MODE_SEL_I;
            end else if (STEP_I && !pl_d) begin
                ps_d = 1'b1;
            end
            if (!AUTO_EN_I || chg) begin
                fcnt_d = '0;
            end else if (bnd_run && fcnt_q != 16'hFFFF) begin
                fcnt_d = fcnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge PXLCLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q  <= S_WAIT_LOCK;
            settle_q <= '0;
            vs_act_q <= 1'b1;
            fs_q     <= 1'b0;
            mode_q   <= MIN4;
            pl_q     <= 1'b0;
            ps_q     <= 1'b0;
            lv_q     <= MIN4;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            vs_act_q <= vs_act;
            fs_q     <= vs_edge;
            mode_q   <= mode_d;
            pl_q     <= pl_d;
            ps_q     <= ps_d;
            lv_q     <= lv_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign TPG_MODE_O    = mode_q;
    assign DEN_TPG_O     = (state_q == S_RUN);
    assign TX_RST_N_O    = linked;
    assign FRAME_START_O = fs_q;
    assign PENDING_O     = pl_q | ps_q;
    assign STATE_O       = state_q;

endmodule

// File: tb/tb_hdmi_link_sequencer.sv
// tb_hdmi_link_sequencer: directed scoreboard bench for hdmi_link_sequencer.
// Frame and reset-release expectations are queued by stimulus and popped by monitors.
module tb_hdmi_link_sequencer;

    typedef struct packed {
        logic [3:0] mode;
        logic       den;
        logic       pend;
    } exp_t;

    logic       clk = 1'b0;
    logic       RST_I = 1'b1;
    logic       LOCKED_I = 1'b0;
    logic       VGA_VS_I = 1'b1;
    logic       AUTO_EN_I = 1'b0;
    logic       STEP_I = 1'b0;
    logic       SEL_LOAD_I = 1'b0;
    logic [3:0] MODE_SEL_I = 4'd0;
    logic [3:0] TPG_MODE_O;
    logic       DEN_TPG_O;
    logic       TX_RST_N_O;
    logic       FRAME_START_O;
    logic       PENDING_O;
    logic [1:0] STATE_O;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic tx_prev = 1'b0;
    exp_t exp_q[$];
    int   rise_q[$];

    hdmi_link_sequencer #(
        .MODE_MIN(1),
        .MODE_MAX(11),
        .FRAMES_PER_MODE(3),
        .SETTLE_CYCLES(16),
        .VS_ACTIVE_HIGH(1'b0)
    ) dut (
        .PXLCLK_I(clk),
        .RST_I(RST_I),
        .LOCKED_I(LOCKED_I),
        .VGA_VS_I(VGA_VS_I),
        .AUTO_EN_I(AUTO_EN_I),
        .STEP_I(STEP_I),
        .SEL_LOAD_I(SEL_LOAD_I),
        .MODE_SEL_I(MODE_SEL_I),
        .TPG_MODE_O(TPG_MODE_O),
        .DEN_TPG_O(DEN_TPG_O),
        .TX_RST_N_O(TX_RST_N_O),
        .FRAME_START_O(FRAME_START_O),
        .PENDING_O(PENDING_O),
        .STATE_O(STATE_O)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame monitor: every FRAME_START_O pulse consumes one expected record.
    always @(negedge clk) begin
        exp_t got;
        exp_t want;
        if (!RST_I && FRAME_START_O) begin
            got = {TPG_MODE_O, DEN_TPG_O, PENDING_O};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame_unexpected at cyc %0d: mode=%0d den=%0d pend=%0d",
                         cyc, got.mode, got.den, got.pend);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL frame at cyc %0d: got mode=%0d den=%0d pend=%0d want mode=%0d den=%0d pend=%0d",
                             cyc, got.mode, got.den, got.pend, want.mode, want.den, want.pend);
                end
            end
        end
    end

    // Reset-release monitor: each rising TX_RST_N_O must land on the queued cycle.
    always @(negedge clk) begin
        int want_c;
        if (TX_RST_N_O && !tx_prev) begin
            checks++;
            if (rise_q.size() == 0) begin
                errors++;
                $display("FAIL tx_rise_unexpected at cyc %0d", cyc);
            end else begin
                want_c = rise_q.pop_front();
                if (cyc != want_c) begin
                    errors++;
                    $display("FAIL tx_rise_cycle: got %0d want %0d", cyc, want_c);
                end
            end
        end
        tx_prev <= TX_RST_N_O;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic pulse_step();
        STEP_I = 1'b1;
        tick();
        STEP_I = 1'b0;
        tick();
    endtask

    task automatic pulse_load(input logic [3:0] v);
        SEL_LOAD_I = 1'b1;
        MODE_SEL_I = v;
        tick();
        SEL_LOAD_I = 1'b0;
        tick();
    endtask

    // One 10-cycle frame; vsync falling edge starts it.
    task automatic frame(input logic [3:0] m, input logic d);
        exp_t e;
        e.mode = m;
        e.den  = d;
        e.pend = 1'b0;
        exp_q.push_back(e);
        VGA_VS_I = 1'b0;
        tick();
        tick();
        VGA_VS_I = 1'b1;
        repeat (8) tick();
    endtask

    // Lock is sampled at the next edge; release follows 16 edges after that.
    task automatic relock();
        LOCKED_I = 1'b1;
        rise_q.push_back(cyc + 17);
        repeat (20) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_mode", TPG_MODE_O, 1);
        chk("rst_den", DEN_TPG_O, 0);
        chk("rst_txn", TX_RST_N_O, 0);
        chk("rst_fs", FRAME_START_O, 0);
        chk("rst_pend", PENDING_O, 0);
        chk("rst_state", STATE_O, 0);
        RST_I = 1'b0;
        tick();

        // Lock drops for one cycle at settle count 10.
        LOCKED_I = 1'b1;
        repeat (11) tick();
        chk("settle_state", STATE_O, 1);
        chk("settle_txn", TX_RST_N_O, 0);
        LOCKED_I = 1'b0;
        tick();
        chk("glitch_state", STATE_O, 0);
        relock();
        chk("align_state", STATE_O, 2);
        chk("align_den", DEN_TPG_O, 0);
        chk("align_mode", TPG_MODE_O, 1);

        frame(4'd1, 1'b1);
        frame(4'd1, 1'b1);

        // Multiple steps at the top mode give one wrapping advance.
        pulse_load(4'd11);
        chk("load11_pend", PENDING_O, 1);
        frame(4'd11, 1'b1);
        pulse_step();
        pulse_step();
        pulse_step();
        chk("steps_pend", PENDING_O, 1);
        frame(4'd1, 1'b1);

        // Load and step together: load wins.
        SEL_LOAD_I = 1'b1;
        MODE_SEL_I = 4'd9;
        STEP_I = 1'b1;
        tick();
        SEL_LOAD_I = 1'b0;
        STEP_I = 1'b0;
        tick();
        frame(4'd9, 1'b1);

        // Out-of-range loads are ignored and leave a pending step alone.
        pulse_step();
        pulse_load(4'd12);
        pulse_load(4'd0);
        chk("badload_keep_pend", PENDING_O, 1);
        frame(4'd10, 1'b1);
        pulse_load(4'd12);
        pulse_load(4'd0);
        chk("badload_pend", PENDING_O, 0);
        frame(4'd10, 1'b1);

        // Auto-advance every third frame; one frame with it off restarts the count.
        pulse_load(4'd1);
        frame(4'd1, 1'b1);
        AUTO_EN_I = 1'b1;
        frame(4'd1, 1'b1);
        frame(4'd1, 1'b1);
        frame(4'd2, 1'b1);
        frame(4'd2, 1'b1);
        frame(4'd2, 1'b1);
        frame(4'd3, 1'b1);
        frame(4'd3, 1'b1);
        AUTO_EN_I = 1'b0;
        frame(4'd3, 1'b1);
        AUTO_EN_I = 1'b1;
        frame(4'd3, 1'b1);
        frame(4'd3, 1'b1);
        frame(4'd4, 1'b1);
        AUTO_EN_I = 1'b0;

        // Lock loss with a load pending.
        pulse_load(4'd5);
        chk("load5_pend", PENDING_O, 1);
        LOCKED_I = 1'b0;
        tick();
        chk("loss_txn", TX_RST_N_O, 0);
        chk("loss_den", DEN_TPG_O, 0);
        chk("loss_pend", PENDING_O, 0);
        chk("loss_mode", TPG_MODE_O, 4);
        chk("loss_state", STATE_O, 0);
        frame(4'd4, 1'b0);
        relock();
        chk("relock_state", STATE_O, 2);
        chk("relock_mode", TPG_MODE_O, 4);

        // A step pending in ALIGN lands on the first RUN boundary.
        pulse_step();
        chk("align_step_pend", PENDING_O, 1);
        frame(4'd5, 1'b1);

        // Asynchronous reset mid-operation.
        pulse_step();
        RST_I = 1'b1;
        #2;
        chk("arst_mode", TPG_MODE_O, 1);
        chk("arst_state", STATE_O, 0);
        chk("arst_txn", TX_RST_N_O, 0);
        chk("arst_den", DEN_TPG_O, 0);
        chk("arst_pend", PENDING_O, 0);
        tick();
        RST_I = 1'b0;
        repeat (3) tick();

        chk("frames_left", exp_q.size(), 0);
        chk("rises_left", rise_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
